usb_rx_pkt_ctrl: RTL and testbench



---
 rtl/usb_rx_pkt_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_usb_rx_pkt_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_pkt_ctrl.sv
// usb_rx_pkt_ctrl
//   USB receive packet controller. Tracks one packet from the first line
//   edge through sync byte, PID byte, data/CRC bytes and end-of-packet.
//   It also drives the RX FIFO write strobe and the CRC accumulate enable.
//   The controller detects a bad sync byte, a bad PID, an early EOP, data
//   overflow, a CRC failure and an idle-bus timeout. A PID-only (handshake)
//   packet ends without a CRC check.
//
// Ports
//   clk, n_rst     system clock, asynchronous active-low reset
//   shift_enable   bit-period strobe from the timer
//   byte_received  1-cycle pulse: rx_data holds a new byte
//   rx_data[7:0]   received byte (held until the next byte)
//   eop            end-of-packet level
//   d_edge         1-cycle pulse on a line transition
//   crc_ok         CRC unit result, sampled in CRC_CHK
//   receiving      packet reception in progress
//   write_enable   1-cycle FIFO write strobe (PID and each data byte)
//   crc_enable     CRC accumulate enable
//   rcv_error      high while in ERROR
//   err_code[2:0]  last error (0 none, 1 sync, 2 PID, 3 early eop,
//                  4 overflow, 5 CRC, 6 timeout)
//   byte_count     data bytes written in the current packet (PID excluded)
//   pkt_done       1-cycle pulse when a good packet ends
module usb_rx_pkt_ctrl #(
    parameter logic [7:0] SYNC_BYTE   = 8'h54,
    parameter bit         CHECK_PID   = 1'b1,
    parameter int         MAX_BYTES   = 64,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             shift_enable,
    input  logic                             byte_received,
    input  logic [7:0]                       rx_data,
    input  logic                             eop,
    input  logic                             d_edge,
    input  logic                             crc_ok,
    output logic                             receiving,
    output logic                             write_enable,
    output logic                             crc_enable,
    output logic                             rcv_error,
    output logic [2:0]                       err_code,
    output logic [$clog2(MAX_BYTES+1)-1:0]   byte_count,
    output logic                             pkt_done
);

    localparam int CW = $clog2(MAX_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_SYNC     = 3'd1;
    localparam logic [2:0] ERR_PID      = 3'd2;
    localparam logic [2:0] ERR_EOP      = 3'd3;
    localparam logic [2:0] ERR_OVERFLOW = 3'd4;
    localparam logic [2:0] ERR_CRC      = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd6;

    typedef enum logic [3:0] {
        IDLE, SYNC_WAIT, SYNC_CHK, PID_WAIT, PID_CHK, PID_WR,
        DATA_WAIT, DATA_WR, DATA_DONE, CRC_CHK, DONE, ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    err_code_q, err_code_d;
    logic [CW-1:0] byte_count_q, byte_count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          receiving_q, receiving_d;
    logic          write_enable_q, write_enable_d;
    logic          crc_enable_q, crc_enable_d;
    logic          rcv_error_q, rcv_error_d;
    logic          pkt_done_q, pkt_done_d;

    logic timed;
    logic timed_out;
    logic pid_ok;

    assign pid_ok    = (rx_data[3:0] == ~rx_data[7:4]);
    assign timed     = (state_q inside {SYNC_WAIT, SYNC_CHK, PID_WAIT, PID_CHK, PID_WR,
                                        DATA_WAIT, DATA_WR, DATA_DONE, ERROR});
    assign timed_out = timed && (timer_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        err_code_d   = err_code_q;
        byte_count_d = byte_count_q;

        unique case (state_q)
            IDLE: if (d_edge) begin
                state_d      = SYNC_WAIT;
                byte_count_d = '0;
                err_code_d   = ERR_NONE;
            end
            SYNC_WAIT: if (byte_received) state_d = SYNC_CHK;
            SYNC_CHK: begin
                if (rx_data == SYNC_BYTE) state_d = PID_WAIT;
                else begin
                    state_d    = ERROR;
                    err_code_d = ERR_SYNC;
                end
            end
            PID_WAIT: begin
                // eop wins over a byte arriving in the same cycle
                if (eop) begin
                    state_d    = ERROR;
                    err_code_d = ERR_EOP;
                end else if (byte_received) state_d = PID_CHK;
            end
            PID_CHK: begin
                if (!CHECK_PID || pid_ok) state_d = PID_WR;
                else begin
                    state_d    = ERROR;
                    err_code_d = ERR_PID;
                end
            end
            PID_WR: state_d = DATA_WAIT;
            DATA_WAIT: begin
                if (eop) begin
                    // eop straight after the PID is a handshake packet: no CRC
                    if (byte_count_q == '0) state_d = DONE;
                    else begin
                        state_d    = ERROR;
                        err_code_d = ERR_EOP;
                    end
                end else if (byte_received) begin
                    if (byte_count_q == CW'(MAX_BYTES)) begin
                        state_d    = ERROR;
                        err_code_d = ERR_OVERFLOW;
                    end else state_d = DATA_WR;
                end
            end
            DATA_WR: begin
                state_d      = DATA_DONE;
                byte_count_d = byte_count_q + 1'b1;
            end
            DATA_DONE: if (shift_enable) state_d = eop ? CRC_CHK : DATA_WAIT;
            CRC_CHK: begin
                if (crc_ok) state_d = DONE;
                else begin
                    state_d    = ERROR;
                    err_code_d = ERR_CRC;
                end
            end
            DONE:    state_d = IDLE;
            ERROR:   if (eop) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Timeout applies only when no other event moves the FSM. In ERROR
        // it releases the bus and keeps the error code that was recorded.
        if (timed_out && state_d == state_q) begin
            if (state_q == ERROR) state_d = IDLE;
            else begin
                state_d    = ERROR;
                err_code_d = ERR_TIMEOUT;
            end
        end

        // The timer also restarts after reaching its limit. A non-power-of-2
        // TIMEOUT_CYC therefore never wraps past the compare value.
        if (!timed || byte_received || eop || timed_out) timer_d = '0;
        else                                             timer_d = timer_q + 1'b1;
        // Entering ERROR restarts the count so a stuck bus leaves ERROR
        // one full timeout period later.
        if (state_d != state_q && state_d inside {SYNC_WAIT, ERROR}) timer_d = '0;

        // Moore outputs are decoded from the next state and registered.
        // They change in the same cycle as state_q and never glitch.
        receiving_d    = !(state_d inside {IDLE, DONE});
        write_enable_d = (state_d inside {PID_WR, DATA_WR});
        crc_enable_d   = (state_d inside {DATA_WAIT, DATA_WR, DATA_DONE});
        rcv_error_d    = (state_d == ERROR);
        pkt_done_d     = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then sample the values from before the edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            err_code_q     <= ERR_NONE;
            byte_count_q   <= '0;
            timer_q        <= '0;
            receiving_q    <= 1'b0;
            write_enable_q <= 1'b0;
            crc_enable_q   <= 1'b0;
            rcv_error_q    <= 1'b0;
            pkt_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            err_code_q     <= err_code_d;
            byte_count_q   <= byte_count_d;
            timer_q        <= timer_d;
            receiving_q    <= receiving_d;
            write_enable_q <= write_enable_d;
            crc_enable_q   <= crc_enable_d;
            rcv_error_q    <= rcv_error_d;
            pkt_done_q     <= pkt_done_d;
        end
    end

    assign receiving    = receiving_q;
    assign write_enable = write_enable_q;
    assign crc_enable   = crc_enable_q;
    assign rcv_error    = rcv_error_q;
    assign err_code     = err_code_q;
    assign byte_count   = byte_count_q;
    assign pkt_done     = pkt_done_q;

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Directed-vector bench for usb_rx_pkt_ctrl. There are two instances on
// shared stimulus: dut (PID check on) and dut_np (PID check off). Both use
// MAX_BYTES=4 and TIMEOUT_CYC=16.
module tb_usb_rx_pkt_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       shift_enable, byte_received, eop, d_edge, crc_ok;
    logic [7:0] rx_data;

    logic       receiving, write_enable, crc_enable, rcv_error, pkt_done;
    logic [2:0] err_code, byte_count;
    logic       np_receiving, np_write_enable, np_crc_enable, np_rcv_error, np_pkt_done;
    logic [2:0] np_err_code, np_byte_count;

    int n_vec = 0;
    int n_err = 0;
    int we_cnt = 0, pd_cnt = 0, er_cnt = 0, np_we_cnt = 0;
    int we0, pd0, er0, npwe0;

    usb_rx_pkt_ctrl #(.SYNC_BYTE(8'h54), .CHECK_PID(1'b1), .MAX_BYTES(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .byte_received(byte_received),
        .rx_data(rx_data), .eop(eop), .d_edge(d_edge), .crc_ok(crc_ok),
        .receiving(receiving), .write_enable(write_enable), .crc_enable(crc_enable),
        .rcv_error(rcv_error), .err_code(err_code), .byte_count(byte_count), .pkt_done(pkt_done));

    usb_rx_pkt_ctrl #(.SYNC_BYTE(8'h54), .CHECK_PID(1'b0), .MAX_BYTES(4), .TIMEOUT_CYC(16)) dut_np (
        .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .byte_received(byte_received),
        .rx_data(rx_data), .eop(eop), .d_edge(d_edge), .crc_ok(crc_ok),
        .receiving(np_receiving), .write_enable(np_write_enable), .crc_enable(np_crc_enable),
        .rcv_error(np_rcv_error), .err_code(np_err_code), .byte_count(np_byte_count),
        .pkt_done(np_pkt_done));

    always #5 clk = ~clk;

    // Event counters sampled on the falling edge, away from output updates
    always @(negedge clk) begin
        if (write_enable === 1'b1)    we_cnt++;
        if (pkt_done === 1'b1)        pd_cnt++;
        if (rcv_error === 1'b1)       er_cnt++;
        if (np_write_enable === 1'b1) np_we_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        we0 = we_cnt; pd0 = pd_cnt; er0 = er_cnt; npwe0 = np_we_cnt;
    endtask

    task automatic start_pkt();
        d_edge = 1'b1; tick(); d_edge = 1'b0;
    endtask

    // Byte pulse plus two settle cycles
    task automatic send_byte(input logic [7:0] b);
        rx_data = b; byte_received = 1'b1; tick();
        byte_received = 1'b0; tick(); tick();
    endtask

    // Data byte followed by a bit-period strobe back to DATA_WAIT
    task automatic data_byte(input logic [7:0] b);
        send_byte(b);
        shift_enable = 1'b1; tick(); shift_enable = 1'b0;
    endtask

    // From DATA_DONE: eop + strobe -> CRC_CHK, then one more cycle (DONE/ERROR)
    task automatic end_pkt();
        eop = 1'b1; shift_enable = 1'b1; tick();
        shift_enable = 1'b0; tick();
    endtask

    task automatic finish_eop();
        tick(); eop = 1'b0; tick();
    endtask

    task automatic test_reset();
        #2;
        n_vec++; if (receiving !== 1'b0 || write_enable !== 1'b0 || crc_enable !== 1'b0) begin n_err++; $display("FAIL reset_flags got rcv=%b we=%b crc=%b want 000", receiving, write_enable, crc_enable); end
        n_vec++; if (rcv_error !== 1'b0 || pkt_done !== 1'b0) begin n_err++; $display("FAIL reset_err_done got %b%b want 00", rcv_error, pkt_done); end
        n_vec++; if (err_code !== 3'd0 || byte_count !== 3'd0) begin n_err++; $display("FAIL reset_regs got code=%0d cnt=%0d want 0 0", err_code, byte_count); end
        n_rst = 1'b1; tick(); tick();
        n_vec++; if (receiving !== 1'b0) begin n_err++; $display("FAIL reset_idle got receiving=%b want 0", receiving); end
    endtask

    task automatic test_data_packet();
        snap(); crc_ok = 1'b1;
        start_pkt();
        n_vec++; if (receiving !== 1'b1) begin n_err++; $display("FAIL t1_receiving got %b want 1", receiving); end
        send_byte(8'h54); send_byte(8'hE1);
        n_vec++; if (crc_enable !== 1'b1) begin n_err++; $display("FAIL t1_crc_en got %b want 1", crc_enable); end
        data_byte(8'h11); data_byte(8'h22); send_byte(8'h33);
        end_pkt();
        n_vec++; if (pkt_done !== 1'b1 || receiving !== 1'b0) begin n_err++; $display("FAIL t1_done got done=%b rcv=%b want 1 0", pkt_done, receiving); end
        finish_eop();
        n_vec++; if (we_cnt - we0 !== 4) begin n_err++; $display("FAIL t1_writes got %0d want 4", we_cnt - we0); end
        n_vec++; if (byte_count !== 3'd3) begin n_err++; $display("FAIL t1_count got %0d want 3", byte_count); end
        n_vec++; if (pd_cnt - pd0 !== 1) begin n_err++; $display("FAIL t1_pulses got %0d want 1", pd_cnt - pd0); end
        n_vec++; if (err_code !== 3'd0 || er_cnt != er0) begin n_err++; $display("FAIL t1_noerr got code=%0d errcyc=%0d want 0 0", err_code, er_cnt - er0); end
    endtask

    task automatic test_handshake();
        snap(); crc_ok = 1'b0;  // a CRC check would fail, so DONE proves it was skipped
        start_pkt(); send_byte(8'h54); send_byte(8'hD2);
        eop = 1'b1; tick();
        n_vec++; if (pkt_done !== 1'b1 || rcv_error !== 1'b0) begin n_err++; $display("FAIL t2_done got done=%b err=%b want 1 0", pkt_done, rcv_error); end
        n_vec++; if (byte_count !== 3'd0 || we_cnt - we0 !== 1) begin n_err++; $display("FAIL t2_count got cnt=%0d writes=%0d want 0 1", byte_count, we_cnt - we0); end
        tick(); eop = 1'b0; tick();
        n_vec++; if (receiving !== 1'b0 || err_code !== 3'd0) begin n_err++; $display("FAIL t2_idle got rcv=%b code=%0d want 0 0", receiving, err_code); end
    endtask

    task automatic test_bad_sync();
        snap();
        start_pkt(); send_byte(8'h55);
        n_vec++; if (rcv_error !== 1'b1 || err_code !== 3'd1) begin n_err++; $display("FAIL t3_err got err=%b code=%0d want 1 1", rcv_error, err_code); end
        repeat (5) tick();
        n_vec++; if (rcv_error !== 1'b1 || receiving !== 1'b1) begin n_err++; $display("FAIL t3_hold got err=%b rcv=%b want 1 1", rcv_error, receiving); end
        eop = 1'b1; tick(); eop = 1'b0;
        n_vec++; if (rcv_error !== 1'b0 || receiving !== 1'b0) begin n_err++; $display("FAIL t3_idle got err=%b rcv=%b want 0 0", rcv_error, receiving); end
        n_vec++; if (we_cnt != we0 || err_code !== 3'd1) begin n_err++; $display("FAIL t3_nowrite got writes=%0d code=%0d want 0 1", we_cnt - we0, err_code); end
        tick();
    endtask

    task automatic test_pid_check();
        snap();
        start_pkt(); send_byte(8'h54); send_byte(8'hE0);
        n_vec++; if (rcv_error !== 1'b1 || err_code !== 3'd2) begin n_err++; $display("FAIL t4_pid_err got err=%b code=%0d want 1 2", rcv_error, err_code); end
        n_vec++; if (we_cnt != we0) begin n_err++; $display("FAIL t4_pid_nowrite got %0d want 0", we_cnt - we0); end
        n_vec++; if (np_crc_enable !== 1'b1 || np_rcv_error !== 1'b0 || np_err_code !== 3'd0) begin n_err++; $display("FAIL t4_nocheck_state got crc=%b err=%b code=%0d want 1 0 0", np_crc_enable, np_rcv_error, np_err_code); end
        n_vec++; if (np_we_cnt - npwe0 !== 1) begin n_err++; $display("FAIL t4_nocheck_write got %0d want 1", np_we_cnt - npwe0); end
        eop = 1'b1; tick(); tick(); eop = 1'b0; tick();
        n_vec++; if (receiving !== 1'b0 || np_receiving !== 1'b0) begin n_err++; $display("FAIL t4_idle got %b %b want 0 0", receiving, np_receiving); end
    endtask

    task automatic test_overflow();
        snap(); crc_ok = 1'b1;
        start_pkt(); send_byte(8'h54); send_byte(8'hE1);
        data_byte(8'hA0); data_byte(8'hA1); data_byte(8'hA2); data_byte(8'hA3);
        n_vec++; if (byte_count !== 3'd4 || rcv_error !== 1'b0) begin n_err++; $display("FAIL t5_at_max got cnt=%0d err=%b want 4 0", byte_count, rcv_error); end
        send_byte(8'hA4);
        n_vec++; if (rcv_error !== 1'b1 || err_code !== 3'd4) begin n_err++; $display("FAIL t5_ovf got err=%b code=%0d want 1 4", rcv_error, err_code); end
        n_vec++; if (we_cnt - we0 !== 5 || byte_count !== 3'd4) begin n_err++; $display("FAIL t5_writes got writes=%0d cnt=%0d want 5 4", we_cnt - we0, byte_count); end
        eop = 1'b1; tick(); eop = 1'b0; tick();
        n_vec++; if (byte_count !== 3'd4 || receiving !== 1'b0) begin n_err++; $display("FAIL t5_held got cnt=%0d rcv=%b want 4 0", byte_count, receiving); end
    endtask

    task automatic test_timeout_crc();
        start_pkt();
        n_vec++; if (byte_count !== 3'd0 || err_code !== 3'd0) begin n_err++; $display("FAIL t6_clear got cnt=%0d code=%0d want 0 0", byte_count, err_code); end
        send_byte(8'h54);
        rx_data = 8'hE1; byte_received = 1'b1; tick(); byte_received = 1'b0;
        repeat (15) tick();
        n_vec++; if (rcv_error !== 1'b0) begin n_err++; $display("FAIL t6_early got err=%b want 0", rcv_error); end
        tick();
        n_vec++; if (rcv_error !== 1'b1 || err_code !== 3'd6) begin n_err++; $display("FAIL t6_timeout got err=%b code=%0d want 1 6", rcv_error, err_code); end
        repeat (15) tick();
        n_vec++; if (rcv_error !== 1'b1) begin n_err++; $display("FAIL t6_err_hold got err=%b want 1", rcv_error); end
        tick();
        n_vec++; if (rcv_error !== 1'b0 || receiving !== 1'b0 || err_code !== 3'd6) begin n_err++; $display("FAIL t6_release got err=%b rcv=%b code=%0d want 0 0 6", rcv_error, receiving, err_code); end
        snap(); crc_ok = 1'b0;
        start_pkt(); send_byte(8'h54); send_byte(8'hE1); send_byte(8'h5A);
        end_pkt();
        n_vec++; if (rcv_error !== 1'b1 || err_code !== 3'd5 || pd_cnt != pd0) begin n_err++; $display("FAIL t6_crc got err=%b code=%0d done=%0d want 1 5 0", rcv_error, err_code, pd_cnt - pd0); end
        finish_eop();
        n_vec++; if (receiving !== 1'b0) begin n_err++; $display("FAIL t6_crc_idle got %b want 0", receiving); end
    endtask

    task automatic test_reset_mid();
        snap();
        start_pkt(); send_byte(8'h54);
        rx_data = 8'hE1; byte_received = 1'b1; tick(); byte_received = 1'b0; tick();
        n_vec++; if (write_enable !== 1'b1) begin n_err++; $display("FAIL t7_pidwr got %b want 1", write_enable); end
        n_rst = 1'b0; #1;
        n_vec++; if (write_enable !== 1'b0 || receiving !== 1'b0 || crc_enable !== 1'b0) begin n_err++; $display("FAIL t7_async got we=%b rcv=%b crc=%b want 000", write_enable, receiving, crc_enable); end
        tick();
        n_vec++; if (we_cnt - we0 !== 0) begin n_err++; $display("FAIL t7_noglitch got %0d writes want 0", we_cnt - we0); end
        n_rst = 1'b1; tick();
        n_vec++; if (receiving !== 1'b0 || err_code !== 3'd0) begin n_err++; $display("FAIL t7_after got rcv=%b code=%0d want 0 0", receiving, err_code); end
    endtask

    initial begin
        n_rst = 1'b0; shift_enable = 1'b0; byte_received = 1'b0; eop = 1'b0;
        d_edge = 1'b0; crc_ok = 1'b0; rx_data = 8'h00;
        repeat (2) @(posedge clk);
        test_reset();
        test_data_packet();
        test_handshake();
        test_bad_sync();
        test_pid_check();
        test_overflow();
        test_timeout_crc();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
